// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 serial link (transmitter and detector).
package seq_pkg;
    localparam logic [3:0] SEQ_PREAMBLE = 4'b1101;
    localparam int         SEQ_PRE_LEN  = 4;

    typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_PAY, TX_PAR, TX_GAP} seq_tx_state_t;

    function automatic int seq_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/seq_frame_tx_if.sv
// Word-in / serial-out bundle of the frame transmitter.
interface seq_frame_tx_if #(parameter int DATA_W = 8);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_data;
    logic              tx_active;
    logic              frame_done;

    modport master (output in_valid, in_data,
                    input  in_ready, tx_data, tx_active, frame_done);
    modport slave  (input  in_valid, in_data,
                    output in_ready, tx_data, tx_active, frame_done);
endinterface

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register feeding the payload bits.
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         q_msb_o
);
    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        sr_q <= '0;
        else if (load_i)  sr_q <= d_i;
        else if (shift_i) sr_q <= sr_q << 1;
    end

    assign q_msb_o = sr_q[W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1101 preamble, payload MSB-first, zero gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);
    localparam int CNT_W = $clog2(seq_max3(DATA_W, GAP_CYCLES, SEQ_PRE_LEN) + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SEQ_PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
    // The last gap bit is driven from IDLE so a held word is accepted on it.
    localparam seq_tx_state_t AFTER_BITS = (GAP_CYCLES > 1) ? TX_GAP : TX_IDLE;

    seq_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d, act_q, act_d, done_q, done_d;
    logic             accept, shift, q_msb;
    logic [1:0]       pre_idx;

    assign bus.in_ready   = (state_q == TX_IDLE);
    assign accept         = bus.in_valid && (state_q == TX_IDLE);
    assign bus.tx_data    = tx_q;
    assign bus.tx_active  = act_q;
    assign bus.frame_done = done_q;

    seq_piso #(.W(DATA_W)) u_piso (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .shift_i(shift),
        .d_i    (bus.in_data),
        .q_msb_o(q_msb)
    );

`ifdef SEQ_FRAME_TX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       par_q <= 1'b0;
        else if (accept) par_q <= ^bus.in_data;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: if (accept) begin
                state_d = TX_PRE;
                cnt_d   = '0;
            end
            TX_PRE: if (cnt_q == PRE_LAST) begin
                state_d = TX_PAY;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
            TX_PAY: if (cnt_q == PAY_LAST) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                state_d = TX_PAR;
`else
                state_d = AFTER_BITS;
`endif
                cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_FRAME_TX_PARITY_EN
            TX_PAR: begin
                state_d = AFTER_BITS;
                cnt_d   = '0;
            end
`endif
            TX_GAP: if (cnt_q == GAP_LAST) begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Serial outputs are registered from the next state, so the bit lands one cycle after accept.
    always_comb begin
        pre_idx = 2'(SEQ_PRE_LEN - 1) - cnt_d[1:0];
        shift   = (state_d == TX_PAY);
        act_d   = (state_d == TX_PRE) || (state_d == TX_PAY) || (state_d == TX_PAR);
        tx_d    = 1'b0;
        case (state_d)
            TX_PRE:  tx_d = SEQ_PREAMBLE[pre_idx];
            TX_PAY:  tx_d = q_msb;
`ifdef SEQ_FRAME_TX_PARITY_EN
            TX_PAR:  tx_d = par_q;
`endif
            default: tx_d = 1'b0;
        endcase
`ifdef SEQ_FRAME_TX_PARITY_EN
        done_d = (state_d == TX_PAR);
`else
        done_d = (state_d == TX_PAY) && (cnt_d == PAY_LAST);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end
endmodule
